// File: rtl/boundary_pkg.sv
// Shared types and defaults for the scrolling river-boundary store.
package boundary_pkg;

   localparam int DEF_WIDTH = 10;
   localparam int DEF_DEPTH = 16;

   typedef enum logic {
      DIR_TO_HIGH = 1'b0,
      DIR_TO_LOW  = 1'b1
   } dir_e;

   typedef struct packed {
      logic [DEF_WIDTH-1:0] data;
      logic                 valid;
   } entry_t;

endpackage

// File: rtl/boundary_shift_array.sv
// Scrolling store of per-row boundary words: shift/rotate in either direction,
// registered random-access read, registered eject port and occupancy tracking.
module boundary_shift_array
   import boundary_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             direction,
   input  logic             rotate,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   // Module-width view of an entry; the package type fixes the default width.
   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             valid;
   } row_t;

   row_t          r_mem [DEPTH];
   row_t          r_rd;
   row_t          r_out;
   logic [CW-1:0] r_count;

   dir_e          w_dir;
   row_t          w_ej;
   row_t          w_ins;
   row_t          w_rd;
   logic [CW-1:0] w_count_nxt;

   always_comb begin
      w_dir = dir_e'(direction);
      w_ej  = (w_dir == DIR_TO_LOW) ? r_mem[0] : r_mem[DEPTH-1];
      if (rotate)
         w_ins = w_ej;
      else if (in_valid)
         w_ins = '{data: in_data, valid: 1'b1};
      else
         w_ins = '0;
      w_count_nxt = r_count + CW'(w_ins.valid) - CW'(w_ej.valid);
   end

   // Addresses past the last row only exist when DEPTH is not a power of two.
   always_comb begin
      w_rd = '0;
      if (int'(rd_addr) < DEPTH)
         w_rd = r_mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else if (clear) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else if (shift_en) begin
         if (w_dir == DIR_TO_LOW) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++)
               r_mem[i] <= r_mem[i+1];
            r_mem[DEPTH-1] <= w_ins;
         end else begin
            for (int unsigned i = 1; i < DEPTH; i++)
               r_mem[i] <= r_mem[i-1];
            r_mem[0] <= w_ins;
         end
      end
   end

   // Read port samples the pre-edge array, so it still updates during clear.
   always_ff @(posedge clk) begin
      if (!reset)
         r_rd <= '0;
      else
         r_rd <= w_rd;
   end

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         r_out   <= '0;
         r_count <= '0;
      end else if (shift_en) begin
         r_out   <= w_ej;
         r_count <= w_count_nxt;
      end else begin
         r_out.valid <= 1'b0;
      end
   end

   assign in_ready  = shift_en & ~rotate & ~clear;
   assign rd_data   = r_rd.data;
   assign rd_valid  = r_rd.valid;
   assign out_data  = r_out.data;
   assign out_valid = r_out.valid;
   assign count     = r_count;
   assign full      = (r_count == CW'(DEPTH));
   assign empty     = (r_count == '0);

endmodule

// File: tb/tb_boundary_shift_array.sv
// Directed bench for boundary_shift_array with a queue-based reference model.
module tb_boundary_shift_array;

   localparam int W  = 10;
   localparam int D  = 16;
   localparam int AW = $clog2(D);
   localparam int CW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          reset, clear, shift_en, direction, rotate, in_valid;
   logic [W-1:0]  in_data;
   logic          in_ready;
   logic [AW-1:0] rd_addr;
   logic [W-1:0]  rd_data, out_data;
   logic          rd_valid, out_valid, full, empty;
   logic [CW-1:0] count;

   int n_tests = 0;
   int n_fail  = 0;

   boundary_shift_array #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .reset(reset), .clear(clear), .shift_en(shift_en),
      .direction(direction), .rotate(rotate), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .out_data(out_data),
      .out_valid(out_valid), .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   // Reference model: rows as a queue, index 0 at the front.
   typedef struct packed {
      logic [W-1:0] d;
      logic         v;
   } ent_t;

   ent_t m_q[$];
   ent_t m_rd, m_out;
   logic m_started = 1'b0;

   initial begin
      for (int i = 0; i < D; i++) m_q.push_back('0);
      m_rd  = '0;
      m_out = '0;
   end

   function automatic int m_count();
      int c = 0;
      foreach (m_q[i]) if (m_q[i].v) c++;
      return c;
   endfunction

   always @(posedge clk) begin
      ent_t ej, ins;
      m_started = 1'b1;
      if (!reset) begin
         foreach (m_q[i]) m_q[i] = '0;
         m_rd  = '0;
         m_out = '0;
      end else begin
         m_rd = (int'(rd_addr) < D) ? m_q[rd_addr] : '0;
         if (clear) begin
            foreach (m_q[i]) m_q[i] = '0;
            m_out = '0;
         end else if (shift_en) begin
            ej  = direction ? m_q[0] : m_q[D-1];
            ins = rotate ? ej : (in_valid ? '{d: in_data, v: 1'b1} : '0);
            if (!direction) begin
               void'(m_q.pop_back());
               m_q.push_front(ins);
            end else begin
               void'(m_q.pop_front());
               m_q.push_back(ins);
            end
            m_out = ej;
         end else begin
            m_out.v = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, mid low phase.
   always @(negedge clk) begin
      #2;
      if (m_started) begin
         chk("m_rd_data",   int'(rd_data),   int'(m_rd.d));
         chk("m_rd_valid",  int'(rd_valid),  int'(m_rd.v));
         chk("m_out_valid", int'(out_valid), int'(m_out.v));
         chk("m_out_data",  int'(out_data),  int'(m_out.d));
         chk("m_count",     int'(count),     m_count());
         chk("m_full",      int'(full),      int'(m_count() == D));
         chk("m_empty",     int'(empty),     int'(m_count() == 0));
         chk("m_in_ready",  int'(in_ready),  int'(shift_en & ~rotate & ~clear));
      end
   end

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   int pulses;

   initial begin
      reset = 1'b0; clear = 1'b0; shift_en = 1'b0; direction = 1'b0;
      rotate = 1'b0; in_valid = 1'b0; in_data = '0; rd_addr = '0;
      tick(); tick();
      reset = 1'b1;

      // Random fill, then a single reset cycle.
      shift_en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_data  = W'($urandom);
         in_valid = 1'($urandom);
         direction = 1'($urandom);
         tick();
      end
      shift_en = 1'b0;
      reset = 1'b0;
      tick();
      chk("rst_count", int'(count), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      reset = 1'b1;
      direction = 1'b0;
      for (int a = 0; a < D; a++) begin
         rd_addr = AW'(a);
         tick();
         chk("rst_rd", int'({rd_data, rd_valid}), 0);
      end

      // Push 1..16 toward higher index.
      shift_en = 1'b1; in_valid = 1'b1;
      for (int k = 1; k <= D; k++) begin
         in_data = W'(k);
         tick();
         if (k == 1) chk("first_eject_bubble", int'(out_valid), 0);
      end
      shift_en = 1'b0;
      chk("fill_full", int'(full), 1);
      chk("fill_count", int'(count), 16);
      rd_addr = 0;  tick(); chk("fill_rd0", int'(rd_data), 16);
      rd_addr = 15; tick(); chk("fill_rd15", int'(rd_data), 1);

      // 17th insertion ejects the oldest word.
      shift_en = 1'b1; in_data = 99;
      tick();
      shift_en = 1'b0;
      chk("ovf_out_data", int'(out_data), 1);
      chk("ovf_out_valid", int'(out_valid), 1);
      chk("ovf_count", int'(count), 16);
      rd_addr = 0; tick(); chk("ovf_rd0", int'(rd_data), 99);

      // Same-edge shift and read returns the pre-shift row.
      rd_addr = 3; shift_en = 1'b1; in_data = 50;
      tick();
      shift_en = 1'b0;
      chk("same_edge_rd3", int'(rd_data), 14);
      chk("same_edge_out", int'(out_data), 2);

      // Rotate toward lower index for a full revolution.
      shift_en = 1'b1; direction = 1'b1; rotate = 1'b1; pulses = 0;
      #1 chk("rot_in_ready", int'(in_ready), 0);
      for (int k = 0; k < D; k++) begin
         tick();
         if (out_valid) pulses++;
         chk("rot_count", int'(count), 16);
      end
      shift_en = 1'b0; rotate = 1'b0; direction = 1'b0;
      chk("rot_pulses", pulses, 16);
      rd_addr = 0; tick(); chk("rot_rd0", int'(rd_data), 50);
      rd_addr = 5; tick(); chk("rot_rd5", int'(rd_data), 13);

      // Five valid words, then bubbles until the oldest falls out.
      reset = 1'b0; tick(); reset = 1'b1;
      shift_en = 1'b1; in_valid = 1'b1;
      for (int k = 11; k <= 15; k++) begin
         in_data = W'(k);
         tick();
      end
      in_valid = 1'b0; in_data = 10'h3ff;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("bubble_count", int'(count), (k < 12) ? 5 : 4);
      end
      chk("bubble_eject_data", int'(out_data), 11);
      chk("bubble_eject_valid", int'(out_valid), 1);
      shift_en = 1'b0;

      // Clear together with shift: array empties, read sees pre-clear row.
      rd_addr = 12; tick();
      chk("pre_clear_rd12", int'(rd_data), 15);
      clear = 1'b1; shift_en = 1'b1; in_valid = 1'b1; in_data = 7;
      tick();
      clear = 1'b0; shift_en = 1'b0; in_valid = 1'b0;
      chk("clr_count", int'(count), 0);
      chk("clr_empty", int'(empty), 1);
      chk("clr_out_valid", int'(out_valid), 0);
      chk("clr_rd12", int'(rd_data), 15);
      tick();
      chk("post_clr_rd12", int'(rd_valid), 0);

      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
